program_memory_loader: RTL and testbench

//  Boot-time controller for a writable program memory (RAM variant of the instruction store).

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/byte_word_packer.sv | 39 +++
 rtl/program_memory_loader.sv | 135 +++++++++++++
 tb/tb_program_memory_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program memory loader.
//   state_t          : loader FSM encoding (3 bits)
//   BYTES_PER_WORD   : stream bytes packed into one instruction word
//   NOP_INSTRUCTION  : value handed to the CPU whenever fetch does not own memory
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      LOAD   = 3'd2,
      WRITE  = 3'd3,
      RUN    = 3'd4,
      ERROR  = 3'd5
   } state_t;

   localparam int          BYTES_PER_WORD  = 4;
   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   clear      in   restart packing at byte 0 with an all-zero word
//   byte_en    in   insert byte_in at the current byte index
//   byte_in    in   8-bit data
//   word_out   out  packed word register
//   word_full  out  this cycle's byte_en completes the word
module byte_word_packer
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_full
);

   logic [1:0]  r_idx;
   logic [31:0] r_word;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         r_idx  <= 2'd0;
         r_word <= '0;
      end else if (byte_en) begin
         // byte k lands in bits [8k+7:8k]
         r_word[{r_idx, 3'b000} +: 8] <= byte_in;
         r_idx                        <= r_idx + 2'd1;
      end
   end

   assign word_out  = r_word;
   assign word_full = byte_en && (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_memory_loader.sv
// Boot-time loader for a writable program memory.
// Receives a header byte N followed by 4*N program bytes (valid/ready),
// writes N words sequentially from address 0, then releases the CPU and
// hands the memory address port to instruction fetch.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
// byte_ready is decoded from state only and never looks at byte_valid.
// Ports:
//   clk, reset (sync, active-low)      start        : request a (re)load
//   byte_in/byte_valid/byte_ready      : program byte stream
//   cpu_address/cpu_instruction/cpu_stall : fetch interface
//   mem_we/mem_address/mem_wdata/mem_rdata : single-port program memory
//   load_done/load_error/words_loaded  : status
//   dbg_state                          : current FSM state for observation
module program_memory_loader
   import program_loader_pkg::*;
#(
   parameter int MEMORY_DEPTH = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   input  logic [DATA_WIDTH-1:0] cpu_address,
   output logic [DATA_WIDTH-1:0] cpu_instruction,
   output logic                  cpu_stall,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output logic [2:0]            dbg_state
);

   state_t              r_state;
   state_t              w_next;
   logic [7:0]          r_n;
   logic [ADDR_WIDTH:0] r_words_loaded;

   logic                w_fire;
   logic                w_hdr_ok;
   logic                w_clear;
   logic                w_byte_en;
   logic [31:0]         w_word;
   logic                w_word_full;
   logic [ADDR_WIDTH:0] w_words_inc;
   logic                w_unused_pc;

   // Only the word-index bits of the PC select memory; the rest wrap.
   assign w_unused_pc = ^{cpu_address[DATA_WIDTH-1:ADDR_WIDTH+2], cpu_address[1:0]};

   assign w_fire      = byte_valid && byte_ready;
   assign w_hdr_ok    = (byte_in != 8'd0) && (byte_in <= 8'(MEMORY_DEPTH));
   assign w_clear     = (r_state == HEADER) && w_fire;
   assign w_byte_en   = (r_state == LOAD) && w_fire;
   assign w_words_inc = r_words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

   byte_word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (w_clear),
      .byte_en   (w_byte_en),
      .byte_in   (byte_in),
      .word_out  (w_word),
      .word_full (w_word_full)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_n            <= 8'd0;
         r_words_loaded <= '0;
      end else begin
         r_state <= w_next;
         if (w_clear && w_hdr_ok) begin
            r_n            <= byte_in;
            r_words_loaded <= '0;
         end else if (r_state == WRITE) begin
            r_words_loaded <= w_words_inc;
         end
      end
   end

   always_comb begin
      w_next          = r_state;
      byte_ready      = 1'b0;
      mem_we          = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      cpu_instruction = NOP_INSTRUCTION;
      cpu_stall       = 1'b1;
      load_done       = 1'b0;
      load_error      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = HEADER;
         end
         HEADER: begin
            byte_ready = 1'b1;
            if (w_fire) w_next = w_hdr_ok ? LOAD : ERROR;
         end
         LOAD: begin
            byte_ready = 1'b1;
            if (w_word_full) w_next = WRITE;
         end
         WRITE: begin
            mem_we      = 1'b1;
            mem_address = r_words_loaded[ADDR_WIDTH-1:0];
            mem_wdata   = w_word;
            w_next      = (8'(w_words_inc) == r_n) ? RUN : LOAD;
         end
         RUN: begin
            cpu_stall       = 1'b0;
            load_done       = 1'b1;
            mem_address     = cpu_address[ADDR_WIDTH+1:2];
            cpu_instruction = mem_rdata;
            if (start) w_next = HEADER;
         end
         ERROR: begin
            load_error = 1'b1;
            if (start) w_next = HEADER;
         end
         default: w_next = IDLE;
      endcase
   end

   assign words_loaded = r_words_loaded;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_program_memory_loader.sv
module tb_program_memory_loader;
   import program_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] cpu_address;
   logic [31:0] cpu_instruction;
   logic        cpu_stall;
   logic        mem_we;
   logic [4:0]  mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        load_done;
   logic        load_error;
   logic [5:0]  words_loaded;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // expected memory writes: {address, data}
   logic [36:0] exp_q[$];
   logic [31:0] tb_mem[32];

   always #5 clk = ~clk;

   program_memory_loader dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .byte_in         (byte_in),
      .byte_valid      (byte_valid),
      .byte_ready      (byte_ready),
      .cpu_address     (cpu_address),
      .cpu_instruction (cpu_instruction),
      .cpu_stall       (cpu_stall),
      .mem_we          (mem_we),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .load_done       (load_done),
      .load_error      (load_error),
      .words_loaded    (words_loaded),
      .dbg_state       (dbg_state)
   );

   // program memory model: synchronous write, combinational read
   initial for (int i = 0; i < 32; i++) tb_mem[i] = 32'h0;
   always @(posedge clk) if (mem_we) tb_mem[mem_address] <= mem_wdata;
   assign mem_rdata = tb_mem[mem_address];

   // monitor: every write the DUT presents is checked against the queue
   always @(negedge clk) begin
      if (mem_we) begin
         logic [36:0] e;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL mem_write_unexpected: got addr=%0d data=%h, required no write",
                     mem_address, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_address, mem_wdata} !== e) begin
               n_errors++;
               $display("FAIL mem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                        mem_address, mem_wdata, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // present one byte, wait (bounded) for acceptance; optional one-cycle gap after
   task automatic send_byte(input logic [7:0] b, input bit gap);
      bit ok = 1'b0;
      int waited = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!ok && waited < 100) begin
         @(negedge clk);
         if (byte_ready) ok = 1'b1;
         else waited++;
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL byte_ready_timeout: got byte_ready=0 for 100 cycles, required 1");
      end
      @(posedge clk); #1;
      if (gap) begin
         byte_valid = 1'b0;
         byte_in    = 8'hFF;
         @(posedge clk); #1;
      end
   endtask

   task automatic send_word(input logic [4:0] addr, input logic [31:0] w, input bit gap);
      exp_q.push_back({addr, w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; cpu_address = 32'h0;

      // reset
      repeat (2) @(posedge clk); #1;
      check("rst_cpu_stall", 64'(cpu_stall), 64'd1);
      check("rst_byte_ready", 64'(byte_ready), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_load_done", 64'(load_done), 64'd0);
      check("rst_cpu_instruction", 64'(cpu_instruction), 64'h0);
      check("rst_words_loaded", 64'(words_loaded), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      reset = 1'b1;

      // load N=2
      pulse_start();
      check("start_to_header", 64'(dbg_state), 64'(HEADER));
      send_byte(8'd2, 1'b0);
      send_word(5'd0, 32'h1234_5678, 1'b0);
      send_word(5'd1, 32'hDEAD_BEEF, 1'b0);
      byte_valid = 1'b0;
      check("write2_load_done", 64'(load_done), 64'd0);
      check("write2_cpu_stall", 64'(cpu_stall), 64'd1);
      @(posedge clk); #1;
      check("run_load_done", 64'(load_done), 64'd1);
      check("run_cpu_stall", 64'(cpu_stall), 64'd0);
      check("run_words_loaded", 64'(words_loaded), 64'd2);
      check("run_byte_ready", 64'(byte_ready), 64'd0);

      // run: fetch owns the port
      cpu_address = 32'h4; #1;
      check("run_addr_pc4", 64'(mem_address), 64'd1);
      check("run_instr_pc4", 64'(cpu_instruction), 64'hDEAD_BEEF);
      cpu_address = 32'h80; #1;
      check("run_addr_wrap", 64'(mem_address), 64'd0);
      check("run_instr_wrap", 64'(cpu_instruction), 64'h1234_5678);
      cpu_address = 32'h7C; #1;
      check("run_addr_top", 64'(mem_address), 64'd31);

      // header errors
      pulse_start();
      check("reload_stall", 64'(cpu_stall), 64'd1);
      check("reload_load_done", 64'(load_done), 64'd0);
      check("reload_instr_nop", 64'(cpu_instruction), 64'h0);
      check("reload_mem_addr", 64'(mem_address), 64'd0);
      send_byte(8'd0, 1'b0);
      byte_valid = 1'b0;
      check("hdr0_error", 64'(load_error), 64'd1);
      repeat (3) @(posedge clk); #1;
      check("hdr0_error_held", 64'(load_error), 64'd1);
      check("hdr0_state", 64'(dbg_state), 64'(ERROR));
      pulse_start();
      check("error_cleared", 64'(load_error), 64'd0);
      send_byte(8'd33, 1'b0);
      byte_valid = 1'b0;
      check("hdr33_error", 64'(load_error), 64'd1);
      pulse_start();
      send_byte(8'd1, 1'b0);
      send_word(5'd0, 32'h1122_3344, 1'b0);
      byte_valid = 1'b0;
      @(posedge clk); #1;
      check("recover_load_done", 64'(load_done), 64'd1);
      check("recover_error", 64'(load_error), 64'd0);
      check("recover_words", 64'(words_loaded), 64'd1);

      // N=32 is legal; abort after two bytes of word 0
      pulse_start();
      send_byte(8'd32, 1'b0);
      check("hdr32_state", 64'(dbg_state), 64'(LOAD));
      check("hdr32_no_error", 64'(load_error), 64'd0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      byte_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_state", 64'(dbg_state), 64'(IDLE));
      check("abort_byte_ready", 64'(byte_ready), 64'd0);
      check("abort_words", 64'(words_loaded), 64'd0);
      check("abort_stall", 64'(cpu_stall), 64'd1);
      reset = 1'b1;

      // gapped stream reload, N=1
      pulse_start();
      send_byte(8'd1, 1'b1);
      send_word(5'd0, 32'hDDCC_BBAA, 1'b1);
      byte_valid = 1'b0;
      check("gap_load_done", 64'(load_done), 64'd1);
      check("gap_words", 64'(words_loaded), 64'd1);
      cpu_address = 32'h0; #1;
      check("gap_instr", 64'(cpu_instruction), 64'hDDCC_BBAA);

      repeat (3) @(posedge clk); #1;
      check("writes_outstanding", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
